// File: rtl/qam_symbol_pacer.sv
// Sample-enable generator, symbol-boundary counter and symbol FIFO feeding the QAM mixer.
// Outputs are registered; the input side is valid/ready with s_ready = !full.
module qam_symbol_pacer #(
  parameter int BPS             = 2,
  parameter int SAMPLE_DIV      = 8,
  parameter int SAMPLES_PER_SYM = 125,
  parameter int FIFO_DEPTH      = 4,
  parameter logic [BPS-1:0] IDLE_SYMBOL = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [BPS-1:0]                   s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic                             sample_en,
  output logic                             sym_strobe,
  output logic [BPS-1:0]                   sym_out,
  output logic                             sym_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic [7:0]                       underflow_cnt
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam int SW = $clog2(SAMPLES_PER_SYM + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] CLK_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [SW-1:0] SMP_LAST = SW'(SAMPLES_PER_SYM - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]     state;
  logic [CW-1:0]  clk_cnt;
  logic [SW-1:0]  smp_cnt;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [BPS-1:0] mem [FIFO_DEPTH];

  logic           sample_tick;
  logic           boundary;
  logic           push;
  logic           pop;
  logic [LW-1:0]  level_nxt;

  // Pop is judged on the pre-edge level, so a push landing on the boundary edge waits.
  always_comb begin
    sample_tick = en && (clk_cnt == CLK_LAST);
    boundary    = sample_tick && (smp_cnt == SMP_LAST);
    push        = s_valid && s_ready;
    pop         = boundary && (fifo_level != '0);
    level_nxt   = fifo_level;
    if (push && !pop)
      level_nxt = fifo_level + LW'(1);
    else if (!push && pop)
      level_nxt = fifo_level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_OFF;
      clk_cnt       <= '0;
      smp_cnt       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      s_ready       <= 1'b1;
      sample_en     <= 1'b0;
      sym_strobe    <= 1'b0;
      sym_out       <= IDLE_SYMBOL;
      sym_valid     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= level_nxt;
      s_ready    <= (level_nxt != LVL_FULL);

      if (!en) begin
        state      <= ST_OFF;
        clk_cnt    <= '0;
        smp_cnt    <= '0;
        sample_en  <= 1'b0;
        sym_strobe <= 1'b0;
        sym_out    <= IDLE_SYMBOL;
        sym_valid  <= 1'b0;
      end else begin
        clk_cnt    <= sample_tick ? '0 : clk_cnt + CW'(1);
        sample_en  <= sample_tick;
        sym_strobe <= boundary;
        if (sample_tick)
          smp_cnt <= boundary ? '0 : smp_cnt + SW'(1);

        if (boundary) begin
          if (pop) begin
            sym_out   <= mem[rd_ptr];
            sym_valid <= 1'b1;
            state     <= ST_RUN;
          end else begin
            sym_out   <= IDLE_SYMBOL;
            sym_valid <= 1'b0;
            // Only a starved RUN counts; idling in WAIT is expected.
            if (state == ST_RUN && underflow_cnt != 8'hFF)
              underflow_cnt <= underflow_cnt + 8'd1;
            state <= ST_WAIT;
          end
        end else if (state == ST_OFF) begin
          state <= ST_WAIT;
        end
      end
    end
  end

endmodule

// File: tb/tb_qam_symbol_pacer.sv
// Bench for qam_symbol_pacer: two instances (BPS=2 idle 0, BPS=4 idle 4'hA) share stimulus
// and are compared each cycle against a boundary-arithmetic reference model.
module tb_qam_symbol_pacer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] s_data = 4'd0;
  logic       s_valid = 1'b0;

  logic       a_s_ready, a_sample_en, a_sym_strobe, a_sym_valid;
  logic [1:0] a_sym_out;
  logic [2:0] a_fifo_level;
  logic [7:0] a_underflow_cnt;

  logic       b_s_ready, b_sample_en, b_sym_strobe, b_sym_valid;
  logic [3:0] b_sym_out;
  logic [2:0] b_fifo_level;
  logic [7:0] b_underflow_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  qam_symbol_pacer #(.BPS(2), .SAMPLE_DIV(4), .SAMPLES_PER_SYM(3), .FIFO_DEPTH(4),
                     .IDLE_SYMBOL(2'b00)) dut_a_i (
    .clk(clk), .rst(rst), .en(en), .s_data(s_data[1:0]), .s_valid(s_valid),
    .s_ready(a_s_ready), .sample_en(a_sample_en), .sym_strobe(a_sym_strobe),
    .sym_out(a_sym_out), .sym_valid(a_sym_valid), .fifo_level(a_fifo_level),
    .underflow_cnt(a_underflow_cnt));

  qam_symbol_pacer #(.BPS(4), .SAMPLE_DIV(4), .SAMPLES_PER_SYM(3), .FIFO_DEPTH(4),
                     .IDLE_SYMBOL(4'hA)) dut_b_i (
    .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid),
    .s_ready(b_s_ready), .sample_en(b_sample_en), .sym_strobe(b_sym_strobe),
    .sym_out(b_sym_out), .sym_valid(b_sym_valid), .fifo_level(b_fifo_level),
    .underflow_cnt(b_underflow_cnt));

  // Reference model: boundaries are every 12th enabled edge, samples every 4th.
  logic [3:0] q[$];
  int         n_en = 0;
  logic       m_se = 1'b0, m_ss = 1'b0, m_sv = 1'b0, m_rdy = 1'b1, m_run = 1'b0;
  logic [3:0] m_sd = 4'd0;
  logic [2:0] m_lvl = 3'd0;
  logic [7:0] m_uf = 8'd0;

  initial begin
    logic do_push;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        n_en = 0; m_se = 0; m_ss = 0; m_sv = 0; m_sd = 0; m_uf = 0; m_run = 0;
        m_rdy = 1; m_lvl = 0;
      end else begin
        do_push = s_valid && (q.size() < 4);
        if (en) begin
          n_en = n_en + 1;
          m_se = (n_en % 4 == 0);
          m_ss = (n_en % 12 == 0);
          if (m_ss) begin
            if (q.size() > 0) begin
              m_sd = q.pop_front();
              m_sv = 1; m_run = 1;
            end else begin
              m_sv = 0;
              if (m_run && m_uf < 8'd255) m_uf = m_uf + 8'd1;
              m_run = 0;
            end
          end
        end else begin
          n_en = 0; m_se = 0; m_ss = 0; m_sv = 0; m_run = 0;
        end
        if (do_push) q.push_back(s_data);
        m_lvl = 3'(q.size());
        m_rdy = (q.size() < 4);
      end
    end
  end

  wire [16:0] dut_a = {a_sample_en, a_sym_strobe, a_sym_out, a_sym_valid, a_s_ready,
                       a_fifo_level, a_underflow_cnt};
  wire [18:0] dut_b = {b_sample_en, b_sym_strobe, b_sym_out, b_sym_valid, b_s_ready,
                       b_fifo_level, b_underflow_cnt};
  wire [16:0] mdl_a = {m_se, m_ss, (m_sv ? m_sd[1:0] : 2'b00), m_sv, m_rdy, m_lvl, m_uf};
  wire [18:0] mdl_b = {m_se, m_ss, (m_sv ? m_sd : 4'hA), m_sv, m_rdy, m_lvl, m_uf};

  task automatic do_reset();
    en = 0; s_valid = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++;
    if (dut_a !== 17'b0_0_00_0_1_000_00000000) begin
      n_fail++; $display("FAIL reset_a got %h required %h", dut_a, 17'b0_0_00_0_1_000_00000000);
    end
    n_chk++;
    if (dut_b !== {2'b00, 4'hA, 2'b01, 3'd0, 8'd0}) begin
      n_fail++; $display("FAIL reset_b got %h required %h", dut_b, {2'b00, 4'hA, 2'b01, 3'd0, 8'd0});
    end
    rst = 0;
    s_valid = 1; s_data = 4'h7;
    @(negedge clk); s_valid = 0; en = 1;
    repeat (14) @(negedge clk);
    #2 rst = 1;
    #1;
    n_chk++;
    if (dut_a !== 17'b0_0_00_0_1_000_00000000) begin
      n_fail++; $display("FAIL async_reset_a got %h required %h", dut_a, 17'b0_0_00_0_1_000_00000000);
    end
    n_chk++;
    if (b_sym_out !== 4'hA || b_fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL async_reset_b sym_out=%h level=%0d required A/0", b_sym_out, b_fifo_level);
    end
    @(negedge clk); rst = 0; en = 0;
  endtask

  task automatic test_timing();
    en = 1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      n_chk++;
      if (dut_a !== mdl_a || dut_b !== mdl_b) begin
        n_fail++; $display("FAIL timing_lock c=%0d a=%h exp=%h b=%h exp=%h", c, dut_a, mdl_a, dut_b, mdl_b);
      end
      if (c == 3 || c == 4 || c == 8) begin
        n_chk++;
        if (a_sample_en !== (c != 3)) begin
          n_fail++; $display("FAIL sample_en_c%0d got %b required %b", c, a_sample_en, c != 3);
        end
      end
      if (c == 11 || c == 12 || c == 24) begin
        n_chk++;
        if (a_sym_strobe !== (c != 11)) begin
          n_fail++; $display("FAIL sym_strobe_c%0d got %b required %b", c, a_sym_strobe, c != 11);
        end
      end
    end
  endtask

  task automatic test_sequence();
    logic [1:0] exp_sym [5];
    logic       exp_vld [5];
    logic [7:0] exp_uf  [5];
    int         k;
    exp_sym = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd0};
    exp_vld = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_uf  = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
    do_reset();
    s_valid = 1; s_data = 4'h2; @(negedge clk);
    s_data = 4'h1; @(negedge clk);
    s_data = 4'h3; @(negedge clk);
    s_valid = 0; en = 1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      n_chk++;
      if (dut_a !== mdl_a || dut_b !== mdl_b) begin
        n_fail++; $display("FAIL seq_lock c=%0d a=%h exp=%h b=%h exp=%h", c, dut_a, mdl_a, dut_b, mdl_b);
      end
      if (c % 12 == 0) begin
        k = c / 12 - 1;
        n_chk++;
        if (a_sym_out !== exp_sym[k] || a_sym_valid !== exp_vld[k] || a_underflow_cnt !== exp_uf[k]) begin
          n_fail++;
          $display("FAIL seq_boundary%0d got sym=%0d vld=%b uf=%0d required sym=%0d vld=%b uf=%0d",
                   k + 1, a_sym_out, a_sym_valid, a_underflow_cnt, exp_sym[k], exp_vld[k], exp_uf[k]);
        end
      end
    end
  endtask

  task automatic test_fill();
    do_reset();
    s_valid = 1;
    repeat (8) begin
      s_data = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    n_chk++;
    if (a_fifo_level !== 3'd4 || a_s_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_full level=%0d ready=%b required 4/0", a_fifo_level, a_s_ready);
    end
    en = 1;
    for (int c = 1; c <= 40; c++) begin
      s_data = 4'($urandom_range(0, 15));
      @(negedge clk);
      n_chk++;
      if (dut_a !== mdl_a || dut_b !== mdl_b) begin
        n_fail++; $display("FAIL fill_lock c=%0d a=%h exp=%h b=%h exp=%h", c, dut_a, mdl_a, dut_b, mdl_b);
      end
      if (c == 12 || c == 13) begin
        n_chk++;
        if (a_s_ready !== (c == 12) || a_fifo_level !== ((c == 12) ? 3'd3 : 3'd4)) begin
          n_fail++; $display("FAIL fill_pop_c%0d ready=%b level=%0d", c, a_s_ready, a_fifo_level);
        end
      end
    end
    s_valid = 0;
  endtask

  task automatic test_boundary_push();
    do_reset();
    en = 1;
    repeat (11) @(negedge clk);
    s_valid = 1; s_data = 4'h3;
    @(negedge clk);
    s_valid = 0;
    n_chk++;
    if (a_sym_strobe !== 1'b1 || a_sym_valid !== 1'b0 || a_sym_out !== 2'd0 || a_fifo_level !== 3'd1) begin
      n_fail++; $display("FAIL bpush_edge strobe=%b vld=%b sym=%0d level=%0d required 1/0/0/1",
                         a_sym_strobe, a_sym_valid, a_sym_out, a_fifo_level);
    end
    repeat (12) @(negedge clk);
    n_chk++;
    if (a_sym_strobe !== 1'b1 || a_sym_valid !== 1'b1 || a_sym_out !== 2'd3 || a_fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL bpush_next strobe=%b vld=%b sym=%0d level=%0d required 1/1/3/0",
                         a_sym_strobe, a_sym_valid, a_sym_out, a_fifo_level);
    end
  endtask

  task automatic test_en_drop();
    int wait_c;
    do_reset();
    s_valid = 1; s_data = 4'h1; @(negedge clk);
    s_data = 4'h2; @(negedge clk);
    s_valid = 0; en = 1;
    repeat (17) @(negedge clk);
    en = 0;
    @(negedge clk);
    n_chk++;
    if (a_sample_en !== 1'b0 || a_sym_strobe !== 1'b0 || a_sym_out !== 2'd0 ||
        a_sym_valid !== 1'b0 || a_fifo_level !== 3'd1 || b_sym_out !== 4'hA) begin
      n_fail++; $display("FAIL endrop_off se=%b ss=%b sym=%0d vld=%b level=%0d bsym=%h",
                         a_sample_en, a_sym_strobe, a_sym_out, a_sym_valid, a_fifo_level, b_sym_out);
    end
    en = 1;
    wait_c = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      n_chk++;
      if (dut_a !== mdl_a || dut_b !== mdl_b) begin
        n_fail++; $display("FAIL endrop_lock c=%0d a=%h exp=%h b=%h exp=%h", c, dut_a, mdl_a, dut_b, mdl_b);
      end
      if (a_sym_strobe === 1'b1 && wait_c == 0) wait_c = c;
    end
    n_chk++;
    if (wait_c != 12) begin
      n_fail++; $display("FAIL endrop_restart first strobe after %0d cycles required 12", wait_c);
    end
    n_chk++;
    if (a_sym_out !== 2'd0 || a_underflow_cnt !== 8'd1) begin
      n_fail++; $display("FAIL endrop_after sym=%0d uf=%0d required 0/1", a_sym_out, a_underflow_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    en = 1;
    for (int c = 1; c <= 800; c++) begin
      if ($urandom_range(0, 49) == 0) en = ~en;
      s_valid = ($urandom_range(0, 3) == 0);
      s_data = 4'($urandom_range(0, 15));
      @(negedge clk);
      n_chk++;
      if (dut_a !== mdl_a || dut_b !== mdl_b) begin
        n_fail++; $display("FAIL rand_lock c=%0d a=%h exp=%h b=%h exp=%h", c, dut_a, mdl_a, dut_b, mdl_b);
      end
    end
    s_valid = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    en = 1;
    for (int it = 0; it < 300; it++) begin
      s_valid = 1; s_data = 4'($urandom_range(0, 15));
      @(negedge clk);
      s_valid = 0;
      repeat (23) @(negedge clk);
      n_chk++;
      if (dut_a !== mdl_a || dut_b !== mdl_b) begin
        n_fail++; $display("FAIL sat_lock it=%0d a=%h exp=%h b=%h exp=%h", it, dut_a, mdl_a, dut_b, mdl_b);
      end
    end
    n_chk++;
    if (b_underflow_cnt !== 8'd255 || a_underflow_cnt !== 8'd255) begin
      n_fail++; $display("FAIL sat_count a=%0d b=%0d required 255", a_underflow_cnt, b_underflow_cnt);
    end
    n_chk++;
    if (b_sym_out !== 4'hA || b_sym_valid !== 1'b0) begin
      n_fail++; $display("FAIL sat_idle sym=%h vld=%b required A/0", b_sym_out, b_sym_valid);
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_sequence();
    test_fill();
    test_boundary_push();
    test_en_drop();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/qam_symbol_pacer.md
Name: qam_symbol_pacer

Overview:
Parametrised timing and symbol-feed front end for the QAM modulator/demodulator chain. It replaces the fixed divide-by-8 mixer clock and the fixed 1000-cycle input sampler with three pieces: a programmable sample-enable generator, a symbol-boundary counter, and a small symbol FIFO with a valid/ready input. It handles any bits-per-symbol width, inserts idle symbols and counts underflows when no data is available. The mixer and demodulator run from its sample_en; the mixer takes its symbol from sym_out.

Parameters:
BPS, 2, bits per symbol (2 = QPSK, 4 = 16-QAM)
SAMPLE_DIV, 8, clk cycles per sample_en pulse (>=2)
SAMPLES_PER_SYM, 125, sample_en pulses per symbol (>=1)
FIFO_DEPTH, 4, symbol FIFO entries (power of 2, >=2)
IDLE_SYMBOL, 0, BPS-bit value driven on sym_out when no data is available

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  run enable; 0 holds all timing counters at zero
s_data  in  BPS  input symbol
s_valid  in  1  s_data valid
s_ready  out  1  FIFO can accept; equals !full (registered state)
sample_en  out  1  one-cycle pulse every SAMPLE_DIV cycles; drives mixer/demod
sym_strobe  out  1  one-cycle pulse at each symbol boundary, coincident with a sample_en
sym_out  out  BPS  current symbol to the mixer
sym_valid  out  1  1 = sym_out came from the FIFO; 0 = idle fill
fifo_level  out  $clog2(FIFO_DEPTH+1)  entries currently held
underflow_cnt  out  8  saturating count of underflows while in RUN

Behaviour:
- Reset (async assert, sync release): FIFO emptied; all counters 0; state OFF; sample_en=0, sym_strobe=0, sym_out=IDLE_SYMBOL, sym_valid=0, fifo_level=0, s_ready=1, underflow_cnt=0. Reset mid-operation discards FIFO contents and any partially elapsed symbol.
- All outputs are registered.
- FIFO push: on s_valid && s_ready. Accepts in every state, including OFF.
- FIFO pop: only at a symbol boundary with the FIFO non-empty, judged on the pre-edge level.
  - Push into an empty FIFO on the boundary edge is not poppable at that edge.
  - Push and pop on the same edge leave fifo_level unchanged.
  - When full, s_ready=0 even if a pop occurs on the same edge.
- Sample timing, en=1:
  - clk_cnt counts 0..SAMPLE_DIV-1 and wraps.
  - sample_en is high for the single cycle after the edge where clk_cnt was SAMPLE_DIV-1.
  - The first pulse follows the SAMPLE_DIV-th edge at which en was sampled high.
- Symbol timing:
  - smp_cnt counts sample_en pulses 0..SAMPLES_PER_SYM-1.
  - A boundary occurs on every SAMPLES_PER_SYM-th pulse. The first is at edge SAMPLE_DIV*SAMPLES_PER_SYM after en rises.
  - sym_strobe, sym_out and sym_valid update on that same edge.
- en=0: clk_cnt and smp_cnt are cleared, sample_en=0, sym_strobe=0, sym_out=IDLE_SYMBOL, sym_valid=0, state goes to OFF. Dropping en mid-symbol abandons that symbol; a later re-enable restarts timing from zero.
- State machine:
  - OFF: leaves to WAIT on the edge where en=1.
  - WAIT: at a boundary with FIFO non-empty, pop, set sym_valid=1, go to RUN. At a boundary with FIFO empty, sym_out=IDLE_SYMBOL, sym_valid=0, no underflow counted.
  - RUN: at a boundary with FIFO non-empty, pop. At a boundary with FIFO empty, sym_out=IDLE_SYMBOL, sym_valid=0, underflow_cnt increments (saturates at 255), go to WAIT.
  - Any state with en=0 goes to OFF; en has priority over a boundary on the same edge.
- sym_out holds between boundaries.
- underflow_cnt is cleared only by rst.

Test Plan:
1. Params BPS=2, SAMPLE_DIV=4, SAMPLES_PER_SYM=3, FIFO_DEPTH=4. Assert rst mid-run -> all outputs at reset values immediately (async). After release and en=1: sample_en pulses every 4 cycles, first after edge 4; sym_strobe every 12 cycles.
2. Push 2,1,3 before en, then en=1 -> sym_out=2,1,3 on boundaries 1–3 with sym_valid=1. Boundary 4 -> sym_out=0, sym_valid=0, underflow_cnt=1, state WAIT. Boundary 5 -> underflow_cnt stays 1.
3. Hold s_valid=1 with en=0 -> exactly 4 accepted, then s_ready=0 and fifo_level=4. Enable -> each boundary pops, s_ready returns 1 one cycle after the first pop, level stays consistent under simultaneous push/pop.
4. Push into an empty FIFO on the exact boundary edge -> idle symbol output on that boundary; the pushed value appears at the next boundary.
5. Drop en for 1 cycle mid-symbol -> sample_en/sym_strobe stop, sym_out=IDLE_SYMBOL. After re-enable, the next boundary arrives 12 cycles later and FIFO contents are preserved.
6. BPS=4, IDLE_SYMBOL=4'hA: force 300 RUN→WAIT underflow cycles -> underflow_cnt saturates at 255; idle output is 4'hA.
